// File: rtl/sms23_inv_pkg.sv
// Shared constants and types for the inverse power-map S-box (y^41 over GF(2^6)).
package sms23_inv_pkg;

  localparam int          W    = 6;
  localparam logic [6:0]  POLY = 7'h43;
  localparam logic [5:0]  EXP  = 6'd41;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  // One squaring per exponent bit plus one multiply per set bit.
  function automatic int unsigned calc_lat(input logic [W-1:0] e);
    int unsigned n;
    n = W;
    for (int unsigned i = 0; i < W; i++) begin
      n += int'(e[i]);
    end
    return n;
  endfunction

  localparam int unsigned LAT = calc_lat(EXP);

endpackage

// File: rtl/sms23_inv_pow_seq_gf64_poly_mul.sv
// Combinational GF(2^W) multiply: carry-less product reduced modulo POLY.
module gf64_poly_mul #(
  parameter int         W    = sms23_inv_pkg::W,
  parameter logic [W:0] POLY = sms23_inv_pkg::POLY
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] c
);

  localparam int PW = 2 * W - 1;

  logic [PW-1:0] prod;

  always_comb begin
    prod = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (b[i]) begin
        prod = prod ^ (PW'(a) << i);
      end
    end
    // Clear product bits from the top down so each fold only touches lower bits.
    for (int unsigned i = PW - 1; i >= W; i--) begin
      if (prod[i]) begin
        prod = prod ^ (PW'(POLY) << (i - W));
      end
    end
    c = prod[W-1:0];
  end

endmodule

// File: rtl/sms23_inv_pow_seq.sv
// Sequential inverse S-box: out = in^EXP by MSB-first square-and-multiply on one shared multiplier.
module sms23_inv_pow_seq #(
  parameter int           W    = sms23_inv_pkg::W,
  parameter logic [W:0]   POLY = sms23_inv_pkg::POLY,
  parameter logic [W-1:0] EXP  = sms23_inv_pkg::EXP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  import sms23_inv_pkg::*;

  localparam int IW = $clog2(W);

  state_e        state_q, state_d;
  logic [W-1:0]  base_q, base_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          in_ready_q, in_ready_d;
  logic [W-1:0]  mul_a, mul_b, mul_c;

  gf64_poly_mul #(
    .W    (W),
    .POLY (POLY)
  ) u_mul (
    .a (mul_a),
    .b (mul_b),
    .c (mul_c)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    mul_a   = acc_q;
    mul_b   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          base_d  = in_data;
          acc_d   = W'(1);
          idx_d   = IW'(W - 1);
          state_d = SQR;
        end
      end
      SQR: begin
        acc_d = mul_c;
        if (EXP[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      MUL: begin
        mul_b = base_q;
        acc_d = mul_c;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = SQR;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so in_ready stays low throughout reset and rises one cycle after.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign out_data  = (state_q == DONE) ? acc_q : '0;
  assign busy      = (state_q == SQR) || (state_q == MUL);

endmodule

// File: tb/tb_sms23_inv_pow_seq.sv
// Directed bench for sms23_inv_pow_seq, its EXP=1 variant and the standalone multiplier.
module tb_sms23_inv_pow_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_data;
  logic       busy;

  logic       e_in_valid = 1'b0;
  logic       e_in_ready;
  logic [5:0] e_in_data = '0;
  logic       e_out_valid;
  logic       e_out_ready = 1'b0;
  logic [5:0] e_out_data;
  logic       e_busy;

  logic [5:0] m_a = '0;
  logic [5:0] m_b = '0;
  logic [5:0] m_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sms23_inv_pow_seq u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  sms23_inv_pow_seq #(
    .EXP (6'd1)
  ) u_dut_e1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (e_in_valid),
    .in_ready  (e_in_ready),
    .in_data   (e_in_data),
    .out_valid (e_out_valid),
    .out_ready (e_out_ready),
    .out_data  (e_out_data),
    .busy      (e_busy)
  );

  gf64_poly_mul u_mul (
    .a (m_a),
    .b (m_b),
    .c (m_c)
  );

  // Shift-and-add with per-step reduction by z^6 = z + 1.
  function automatic logic [5:0] sw_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r;
    logic [5:0] aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[5] ? ((aa << 1) ^ 6'h03) : (aa << 1);
    end
    return r;
  endfunction

  function automatic logic [5:0] sw_sbox(input logic [5:0] x);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < 20; i++) r = sw_mul(r, x);
    return r;
  endfunction

  task automatic start_op(input logic [5:0] y, output bit to);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = y;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    to = (n >= 50);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [5:0] res);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    lat = cnt;
    res = out_data;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 6'h15;
    repeat (3) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++;
    if (out_data !== 6'h00) begin n_fail++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_capture_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    logic [5:0] ys   [3] = '{6'h00, 6'h01, 6'h3C};
    logic [5:0] exps [3] = '{6'h00, 6'h01, 6'h02};
    int lat;
    logic [5:0] res;
    bit to;
    for (int i = 0; i < 3; i++) begin
      start_op(ys[i], to);
      wait_done(lat, res);
      n_tests++;
      if (to || lat != 9) begin n_fail++; $display("FAIL basic_lat y=%h got=%0d exp=9", ys[i], lat); end
      n_tests++;
      if (res !== exps[i]) begin n_fail++; $display("FAIL basic_data y=%h got=%h exp=%h", ys[i], res, exps[i]); end
      drain();
    end
  endtask

  task automatic test_exhaustive();
    int lat;
    logic [5:0] res;
    logic [5:0] x;
    bit to;
    for (int i = 0; i < 64; i++) begin
      x = 6'(i);
      start_op(sw_sbox(x), to);
      wait_done(lat, res);
      n_tests++;
      if (to || lat != 9) begin n_fail++; $display("FAIL exh_lat x=%h got=%0d exp=9", x, lat); end
      n_tests++;
      if (res !== x) begin n_fail++; $display("FAIL exh_data x=%h got=%h exp=%h", x, res, x); end
      drain();
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    logic [5:0] res;
    bit to;
    start_op(6'h3C, to);
    wait_done(lat, res);
    n_tests++;
    if (to || lat != 9) begin n_fail++; $display("FAIL bp_lat got=%0d exp=9", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
      n_tests++;
      if (out_data !== 6'h02) begin n_fail++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=02", i, out_data); end
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
    end
    drain();
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    start_op(6'h01, to);
    wait_done(lat, res);
    n_tests++;
    if (to || lat != 9 || res !== 6'h01) begin
      n_fail++; $display("FAIL bp_next_op got=%h/%0d exp=01/9", res, lat);
    end
    drain();
  endtask

  task automatic test_ignored_input();
    int lat;
    logic [5:0] res;
    bit to;
    start_op(6'h3C, to);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 6'h2A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL ign_busy cyc=%0d got=%b/%b exp=0/1", i, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    wait_done(lat, res);
    n_tests++;
    if (lat != 5) begin n_fail++; $display("FAIL ign_lat got=%0d exp=5", lat); end
    n_tests++;
    if (res !== 6'h02) begin n_fail++; $display("FAIL ign_data got=%h exp=02", res); end
    drain();
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_queue busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [5:0] res;
    bit to;
    start_op(6'h3C, to);
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 6'h00 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_outputs got=v%b b%b d%h r%b exp=v0 b0 d00 r0", out_valid, busy, out_data, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    start_op(6'h3C, to);
    wait_done(lat, res);
    n_tests++;
    if (to || lat != 9 || res !== 6'h02) begin
      n_fail++; $display("FAIL rmid_fresh got=%h/%0d exp=02/9", res, lat);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 6'h00) begin
      n_fail++; $display("FAIL rdone_outputs got=v%b d%h exp=v0 d00", out_valid, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exp_override();
    logic [5:0] vals [5] = '{6'h00, 6'h01, 6'h2A, 6'h3F, 6'h15};
    int n;
    int cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e_in_valid = 1'b1;
      e_in_data  = vals[i];
      n = 0;
      while (!e_in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      e_in_valid = 1'b0;
      n_tests++;
      if (e_busy !== 1'b1) begin n_fail++; $display("FAIL e1_busy v=%h got=%b exp=1", vals[i], e_busy); end
      cnt = 0;
      while (!e_out_valid && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      n_tests++;
      if (cnt != 7) begin n_fail++; $display("FAIL e1_lat v=%h got=%0d exp=7", vals[i], cnt); end
      n_tests++;
      if (e_out_data !== vals[i]) begin n_fail++; $display("FAIL e1_data got=%h exp=%h", e_out_data, vals[i]); end
      e_out_ready = 1'b1;
      @(negedge clk);
      e_out_ready = 1'b0;
    end
  endtask

  task automatic test_mul();
    logic [5:0] va [5] = '{6'h02, 6'h20, 6'h03, 6'h3F, 6'h00};
    logic [5:0] vb [5] = '{6'h20, 6'h20, 6'h03, 6'h01, 6'h2A};
    logic [5:0] vc [5] = '{6'h03, 6'h30, 6'h05, 6'h3F, 6'h00};
    logic [5:0] exp_c;
    for (int i = 0; i < 5; i++) begin
      m_a = va[i];
      m_b = vb[i];
      #1;
      n_tests++;
      if (m_c !== vc[i]) begin n_fail++; $display("FAIL mul_vec %h*%h got=%h exp=%h", va[i], vb[i], m_c, vc[i]); end
    end
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        m_a = 6'(a);
        m_b = 6'(b);
        exp_c = sw_mul(6'(a), 6'(b));
        #1;
        n_tests++;
        if (m_c !== exp_c) begin n_fail++; $display("FAIL mul_model %h*%h got=%h exp=%h", m_a, m_b, m_c, exp_c); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_exhaustive();
    test_back_pressure();
    test_ignored_input();
    test_reset_mid();
    test_exp_override();
    test_mul();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
